rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Shares the single-port synchronous program ROM between two requesters: instruction fetch and data load (constant tables).
- Sits between the NBBPU core's fetch/load units and the ROM. Drives the ROM's select, read_enable and address; returns ROM read data to the owning requester.
- Uses valid/ready handshakes on both sides, round-robin arbitration, and one outstanding read at a time.

Parameters:
ADDR_WIDTH, 16, width of request addresses and of rom_address
DATA_WIDTH, 16, width of ROM words and response data
ROM_DEPTH, 256, number of implemented ROM words; addresses >= ROM_DEPTH are out of range

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
fetch_req_valid  input  1  fetch request present
fetch_req_ready  output  1  fetch request accepted this cycle
fetch_req_address  input  ADDR_WIDTH  fetch word address
fetch_rsp_valid  output  1  fetch response available
fetch_rsp_ready  input  1  fetch unit consumes response
fetch_rsp_data  output  DATA_WIDTH  fetch response word
fetch_rsp_error  output  1  fetch address was out of range
load_req_valid / load_req_ready / load_req_address / load_rsp_valid / load_rsp_ready / load_rsp_data / load_rsp_error  (same directions, widths and meanings as the fetch_* ports, for the load requester)
rom_select  output  1  to ROM select
rom_read_enable  output  1  to ROM read_enable
rom_address  output  ADDR_WIDTH  to ROM address
rom_read_data  input  DATA_WIDTH  from ROM; valid one cycle after a strobed read, then held until the next strobed read

Behaviour:
- FSM states: IDLE, RESP. Registers: state, owner (0 = fetch, 1 = load), last_grant, error_flag.
- Reset (reset low, asynchronous):
  - state = IDLE, last_grant = load, owner = fetch, error_flag = 0.
  - All *_req_ready, *_rsp_valid, *_rsp_error, rom_select and rom_read_enable = 0.
  - rom_address = 0; *_rsp_data = 0.
  - Reset mid-transaction discards the in-flight response; the requester must re-issue.
- Arbitration in IDLE (combinational grant):
  - Only one requester valid: it wins.
  - Both valid: the requester that is not last_grant wins. Fetch therefore wins the first tie after reset, and the two strictly alternate under continuous contention.
  - The winner's req_ready = 1 in that cycle; the loser's req_ready = 0.
  - req_ready is never asserted in RESP, except as allowed by the optional feature.
- Issue (the cycle a grant is made):
  - rom_address = winner address.
  - In range: rom_select = rom_read_enable = 1.
  - Out of range (address >= ROM_DEPTH): rom_select = 0, no ROM access.
  - At the clock edge: owner = winner, last_grant = winner, error_flag = out-of-range, state -> RESP.
- RESP:
  - The owner's rsp_valid = 1.
  - rsp_data = rom_read_data, or 0 when error_flag = 1.
  - rsp_error = error_flag.
  - The non-owner's rsp_* outputs are 0.
  - ROM strobes are 0, so ROM output is stable.
  - rsp_valid is held until rsp_ready; rsp_data must not change while valid.
  - On rsp_valid & rsp_ready: state -> IDLE.
- Latency:
  - Request accepted at edge k -> rsp_valid from cycle k+1.
  - Base throughput is one read per 2 cycles with rsp_ready tied high.
- Request inputs are ignored (not sampled) outside the grant cycle; requesters hold valid/address until ready.
- All ROM strobes are combinational from state and request inputs; ROM outputs are never combinationally looped to ready.

Optional Feature:
- Macro: ROM_ARBITER_BACK_TO_BACK_EN.
- Defined:
  - In RESP, in the cycle the response handshake completes, arbitration runs as in IDLE and may grant and strobe the ROM in that same cycle.
  - The tie-break uses the just-completed owner as last_grant.
  - With a grant, the state stays RESP with the new owner.
  - This sustains one read per cycle.
  - No grant is made while rsp_ready = 0.
- Undefined: behaviour exactly as above; IDLE is always visited between transactions.

Test Plan:
- Reset then fetch_req_valid = 1, address 0x0010, ROM[0x10] = 0xBEEF, rsp_ready = 1 -> fetch_req_ready = 1 at cycle 0; fetch_rsp_valid = 1 with data 0xBEEF at cycle 1; load_rsp_valid = 0 throughout.
- Both requesters valid continuously (fetch 0x0001, load 0x0002) -> grants alternate fetch, load, fetch, load…; each response is routed to the correct port with its ROM word.
- fetch rsp_ready held 0 for 5 cycles while load_req_valid = 1 -> fetch_rsp_data stable, load_req_ready = 0, rom_select = 0 until the handshake completes; then load is granted.
- load address 0x0100 with ROM_DEPTH = 256 -> rom_select stays 0; load_rsp_valid = 1, load_rsp_error = 1, load_rsp_data = 0x0000.
- reset asserted low in RESP with fetch_rsp_valid = 1 -> all outputs go to 0 immediately (asynchronously); after release, the first tie is granted to fetch.
- With ROM_ARBITER_BACK_TO_BACK_EN, fetch streams addresses 0..7 with rsp_ready = 1 -> 8 responses on 8 consecutive cycles, data = ROM[0..7] in order.

Source files
------------

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous ROM between fetch and load.
// Define ROM_ARBITER_BACK_TO_BACK_EN to allow a new grant in the response-handshake cycle.
module rom_arbiter #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 16,
   parameter int ROM_DEPTH  = 256
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_req_valid,
   output logic                  fetch_req_ready,
   input  logic [ADDR_WIDTH-1:0] fetch_req_address,
   output logic                  fetch_rsp_valid,
   input  logic                  fetch_rsp_ready,
   output logic [DATA_WIDTH-1:0] fetch_rsp_data,
   output logic                  fetch_rsp_error,
   input  logic                  load_req_valid,
   output logic                  load_req_ready,
   input  logic [ADDR_WIDTH-1:0] load_req_address,
   output logic                  load_rsp_valid,
   input  logic                  load_rsp_ready,
   output logic [DATA_WIDTH-1:0] load_rsp_data,
   output logic                  load_rsp_error,
   output logic                  rom_select,
   output logic                  rom_read_enable,
   output logic [ADDR_WIDTH-1:0] rom_address,
   input  logic [DATA_WIDTH-1:0] rom_read_data
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RESP = 1'b1;
   localparam logic FETCH = 1'b0;
   localparam logic LOAD  = 1'b1;

   logic [0:0] state;
   logic owner;
   logic last_grant;
   logic error_flag;

   logic owner_ready;
   logic rsp_done;
   logic arb_en;
   logic grant_fetch;
   logic grant_load;
   logic grant;
   logic out_of_range;
   logic fetch_active;
   logic load_active;
   logic [ADDR_WIDTH-1:0] winner_address;

   assign owner_ready = (owner == LOAD) ? load_rsp_ready : fetch_rsp_ready;
   assign rsp_done    = (state == RESP) & owner_ready;

`ifdef ROM_ARBITER_BACK_TO_BACK_EN
   assign arb_en = reset & ((state == IDLE) | rsp_done);
`else
   assign arb_en = reset & (state == IDLE);
`endif

   // Tie goes to whoever was not served last
   assign grant_fetch = arb_en & fetch_req_valid
                      & (~load_req_valid | (last_grant == LOAD));
   assign grant_load  = arb_en & load_req_valid
                      & (~fetch_req_valid | (last_grant == FETCH));
   assign grant       = grant_fetch | grant_load;

   assign winner_address = grant_load ? load_req_address
                                      : fetch_req_address;
   assign out_of_range   = 64'(winner_address) >= 64'(ROM_DEPTH);

   assign fetch_req_ready = grant_fetch;
   assign load_req_ready  = grant_load;

   assign rom_address     = grant ? winner_address : '0;
   assign rom_select      = grant & ~out_of_range;
   assign rom_read_enable = grant & ~out_of_range;

   assign fetch_active = (state == RESP) & (owner == FETCH);
   assign load_active  = (state == RESP) & (owner == LOAD);

   assign fetch_rsp_valid = fetch_active;
   assign fetch_rsp_error = fetch_active & error_flag;
   assign fetch_rsp_data  = (fetch_active & ~error_flag) ? rom_read_data
                                                         : '0;

   assign load_rsp_valid = load_active;
   assign load_rsp_error = load_active & error_flag;
   assign load_rsp_data  = (load_active & ~error_flag) ? rom_read_data
                                                       : '0;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         owner      <= FETCH;
         last_grant <= LOAD;
         error_flag <= 1'b0;
      end else if (grant) begin
         state      <= RESP;
         owner      <= grant_load;
         last_grant <= grant_load;
         error_flag <= out_of_range;
      end else if (rsp_done) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_rom_arbiter.sv
// Randomized and directed bench for rom_arbiter with a transaction-level model.
// Also exercises the ROM_ARBITER_BACK_TO_BACK_EN streaming mode when defined.
module tb_rom_arbiter;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 256;
`ifdef ROM_ARBITER_BACK_TO_BACK_EN
   localparam bit BTB = 1'b1;
`else
   localparam bit BTB = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic fetch_req_valid = 1'b0;
   logic fetch_req_ready;
   logic [AW-1:0] fetch_req_address = '0;
   logic fetch_rsp_valid;
   logic fetch_rsp_ready = 1'b1;
   logic [DW-1:0] fetch_rsp_data;
   logic fetch_rsp_error;
   logic load_req_valid = 1'b0;
   logic load_req_ready;
   logic [AW-1:0] load_req_address = '0;
   logic load_rsp_valid;
   logic load_rsp_ready = 1'b1;
   logic [DW-1:0] load_rsp_data;
   logic load_rsp_error;
   logic rom_select;
   logic rom_read_enable;
   logic [AW-1:0] rom_address;
   logic [DW-1:0] rom_read_data = '0;

   logic [DW-1:0] rom_mem [DEPTH];

   int n_checks = 0;
   int n_errors = 0;

   rom_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROM_DEPTH(DEPTH)) dut (
      .clock(clock),
      .reset(reset),
      .fetch_req_valid(fetch_req_valid),
      .fetch_req_ready(fetch_req_ready),
      .fetch_req_address(fetch_req_address),
      .fetch_rsp_valid(fetch_rsp_valid),
      .fetch_rsp_ready(fetch_rsp_ready),
      .fetch_rsp_data(fetch_rsp_data),
      .fetch_rsp_error(fetch_rsp_error),
      .load_req_valid(load_req_valid),
      .load_req_ready(load_req_ready),
      .load_req_address(load_req_address),
      .load_rsp_valid(load_rsp_valid),
      .load_rsp_ready(load_rsp_ready),
      .load_rsp_data(load_rsp_data),
      .load_rsp_error(load_rsp_error),
      .rom_select(rom_select),
      .rom_read_enable(rom_read_enable),
      .rom_address(rom_address),
      .rom_read_data(rom_read_data)
   );

   always #5 clock = ~clock;

   // Synchronous ROM: word appears after a strobed read and is then held
   always @(posedge clock)
      if (rom_select && rom_read_enable)
         rom_read_data <= rom_mem[rom_address[7:0]];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Transaction model: one outstanding read, round-robin on ties
   bit m_pend = 1'b0;
   bit m_port = 1'b0;
   bit m_last = 1'b1;
   bit m_err  = 1'b0;
   logic [DW-1:0] m_data = '0;
   logic m_hs, m_can, m_ef, m_el;
   logic [AW-1:0] m_a;
   logic f_acc = 1'b0;
   logic l_acc = 1'b0;

   always @(negedge clock) begin
      if (!reset) begin
         m_pend = 1'b0;
         m_last = 1'b1;
      end
      m_hs  = m_pend && (m_port ? load_rsp_ready : fetch_rsp_ready);
      m_can = reset && (!m_pend || (BTB && m_hs));
      m_ef  = m_can && fetch_req_valid && (!load_req_valid || m_last);
      m_el  = m_can && load_req_valid && (!fetch_req_valid || !m_last);
      m_a   = m_el ? load_req_address : fetch_req_address;
      check("fetch_req_ready", 32'(fetch_req_ready), 32'(m_ef));
      check("load_req_ready", 32'(load_req_ready), 32'(m_el));
      check("fetch_rsp_valid", 32'(fetch_rsp_valid), 32'(m_pend && !m_port));
      check("fetch_rsp_data", 32'(fetch_rsp_data),
            (m_pend && !m_port) ? 32'(m_data) : 32'd0);
      check("fetch_rsp_error", 32'(fetch_rsp_error),
            32'(m_pend && !m_port && m_err));
      check("load_rsp_valid", 32'(load_rsp_valid), 32'(m_pend && m_port));
      check("load_rsp_data", 32'(load_rsp_data),
            (m_pend && m_port) ? 32'(m_data) : 32'd0);
      check("load_rsp_error", 32'(load_rsp_error),
            32'(m_pend && m_port && m_err));
      if (m_ef || m_el) begin
         check("rom_address", 32'(rom_address), 32'(m_a));
         check("rom_select", 32'(rom_select), 32'(m_a < 16'd256));
         check("rom_read_enable", 32'(rom_read_enable), 32'(m_a < 16'd256));
      end else begin
         check("rom_idle_select", 32'(rom_select), 32'd0);
         check("rom_idle_read_enable", 32'(rom_read_enable), 32'd0);
      end
      f_acc = fetch_req_valid && fetch_req_ready;
      l_acc = load_req_valid && load_req_ready;
      if (m_hs) m_pend = 1'b0;
      if (m_ef || m_el) begin
         m_pend = 1'b1;
         m_port = m_el;
         m_err  = !(m_a < 16'd256);
         m_data = m_err ? '0 : rom_mem[m_a[7:0]];
         m_last = m_el;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   int grants[$];
   logic [DW-1:0] got[$];
   int waited;
   int sent;
   int first_cyc;
   int last_cyc;

   initial begin
      for (int i = 0; i < DEPTH; i++) rom_mem[i] = 16'($urandom);
      rom_mem[16] = 16'hBEEF;
      #1 reset = 1'b0;
      fetch_req_valid = 1'b1;
      repeat (2) @(posedge clock);
      #3;
      check("reset_fetch_outs", 32'({fetch_req_ready, fetch_rsp_valid,
            fetch_rsp_error, fetch_rsp_data}), 32'd0);
      check("reset_load_outs", 32'({load_req_ready, load_rsp_valid,
            load_rsp_error, load_rsp_data}), 32'd0);
      check("reset_rom_outs", 32'({rom_select, rom_read_enable,
            rom_address}), 32'd0);
      fetch_req_valid = 1'b0;
      tick();
      reset = 1'b1;

      // Single fetch
      tick();
      fetch_req_valid = 1'b1;
      fetch_req_address = 16'h0010;
      #2;
      check("t1_fetch_ready", 32'(fetch_req_ready), 32'd1);
      check("t1_rom_select", 32'(rom_select), 32'd1);
      tick();
      fetch_req_valid = 1'b0;
      #2;
      check("t1_rsp_valid", 32'(fetch_rsp_valid), 32'd1);
      check("t1_rsp_data", 32'(fetch_rsp_data), 32'hBEEF);
      check("t1_load_quiet", 32'(load_rsp_valid), 32'd0);
      tick();
      tick();

      // Continuous contention alternates grants
      fetch_req_valid = 1'b1;
      fetch_req_address = 16'h0001;
      load_req_valid = 1'b1;
      load_req_address = 16'h0002;
      repeat (12) begin
         #2;
         if (fetch_req_ready) grants.push_back(0);
         if (load_req_ready) grants.push_back(1);
         tick();
      end
      fetch_req_valid = 1'b0;
      load_req_valid = 1'b0;
      check("alt_count", 32'(grants.size()), BTB ? 32'd12 : 32'd6);
      if (grants.size() > 0) check("alt_first", 32'(grants[0]), 32'd1);
      for (int i = 1; i < grants.size(); i++)
         check("alt_order", 32'(grants[i]), 32'(grants[i-1] ^ 1));
      tick();
      tick();

      // Stalled fetch response blocks the load
      fetch_rsp_ready = 1'b0;
      fetch_req_valid = 1'b1;
      fetch_req_address = 16'h0020;
      #2;
      check("stall_fetch_grant", 32'(fetch_req_ready), 32'd1);
      tick();
      fetch_req_valid = 1'b0;
      load_req_valid = 1'b1;
      load_req_address = 16'h0030;
      repeat (5) begin
         #2;
         check("stall_data", 32'(fetch_rsp_data), 32'(rom_mem[32]));
         check("stall_load_ready", 32'(load_req_ready), 32'd0);
         check("stall_rom_select", 32'(rom_select), 32'd0);
         tick();
      end
      fetch_rsp_ready = 1'b1;
      waited = 0;
      #2;
      while (!load_req_ready && waited < 4) begin
         tick();
         #2;
         waited++;
      end
      check("stall_load_grant", 32'(load_req_ready), 32'd1);
      check("stall_wait", 32'(waited), BTB ? 32'd0 : 32'd1);
      tick();
      load_req_valid = 1'b0;
      #2;
      check("stall_load_rsp", 32'(load_rsp_data), 32'(rom_mem[48]));
      tick();
      tick();

      // Out-of-range load
      load_req_valid = 1'b1;
      load_req_address = 16'h0100;
      #2;
      check("oor_ready", 32'(load_req_ready), 32'd1);
      check("oor_select", 32'(rom_select), 32'd0);
      tick();
      load_req_valid = 1'b0;
      #2;
      check("oor_valid", 32'(load_rsp_valid), 32'd1);
      check("oor_error", 32'(load_rsp_error), 32'd1);
      check("oor_data", 32'(load_rsp_data), 32'd0);
      tick();
      tick();

      // Asynchronous reset while a response is pending
      fetch_rsp_ready = 1'b0;
      fetch_req_valid = 1'b1;
      fetch_req_address = 16'h0005;
      tick();
      fetch_req_valid = 1'b0;
      #1;
      check("rst_pre_valid", 32'(fetch_rsp_valid), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("rst_fetch_outs", 32'({fetch_req_ready, fetch_rsp_valid,
            fetch_rsp_error, fetch_rsp_data}), 32'd0);
      check("rst_rom_outs", 32'({rom_select, rom_read_enable,
            rom_address}), 32'd0);
      tick();
      reset = 1'b1;
      fetch_rsp_ready = 1'b1;
      tick();
      fetch_req_valid = 1'b1;
      fetch_req_address = 16'h0007;
      load_req_valid = 1'b1;
      load_req_address = 16'h0008;
      #2;
      check("rst_first_tie", 32'(fetch_req_ready), 32'd1);
      check("rst_first_tie_load", 32'(load_req_ready), 32'd0);
      tick();
      fetch_req_valid = 1'b0;
      repeat (3) tick();
      load_req_valid = 1'b0;
      repeat (2) tick();

      // Randomized traffic, requesters hold until accepted
      f_acc = 1'b0;
      l_acc = 1'b0;
      repeat (400) begin
         tick();
         if (!fetch_req_valid || f_acc) begin
            fetch_req_valid = ($urandom_range(0, 2) != 0);
            fetch_req_address = 16'($urandom_range(0, 300));
         end
         if (!load_req_valid || l_acc) begin
            load_req_valid = ($urandom_range(0, 2) != 0);
            load_req_address = 16'($urandom_range(0, 300));
         end
         fetch_rsp_ready = ($urandom_range(0, 3) != 0);
         load_rsp_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      fetch_req_valid = 1'b0;
      load_req_valid = 1'b0;
      fetch_rsp_ready = 1'b1;
      load_rsp_ready = 1'b1;
      repeat (3) tick();

`ifdef ROM_ARBITER_BACK_TO_BACK_EN
      // Streaming fetch of words 0..7
      sent = 0;
      first_cyc = -1;
      last_cyc = -1;
      fetch_req_valid = 1'b1;
      fetch_req_address = 16'd0;
      for (int c = 0; c < 20; c++) begin
         #2;
         if (fetch_rsp_valid && fetch_rsp_ready) begin
            got.push_back(fetch_rsp_data);
            if (first_cyc < 0) first_cyc = c;
            last_cyc = c;
         end
         if (fetch_req_valid && fetch_req_ready) sent++;
         tick();
         if (sent >= 8) fetch_req_valid = 1'b0;
         else fetch_req_address = 16'(sent);
      end
      check("btb_count", 32'(got.size()), 32'd8);
      check("btb_span", 32'(last_cyc - first_cyc), 32'd7);
      for (int i = 0; i < got.size() && i < 8; i++)
         check("btb_data", 32'(got[i]), 32'(rom_mem[i]));
`endif

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
